// File: rtl/mem_delayed.sv
// Word-addressed data memory with a fixed access latency and a req/ack handshake.
// One access in flight at a time; o_busy backpressures the requester.
module mem_delayed #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_req,
  input  logic             i_wr_req,
  input  logic [15:0]      i_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_ack,
  output logic             o_busy,
  output logic             o_oob_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [0:0]       r_state;
  logic [3:0]       r_cnt;
  logic [15:0]      r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_is_wr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_in_range;
  logic             w_done;
  logic [AW-1:0]    w_idx;

  // Full 16-bit compare so high addresses never alias into the array.
  assign w_in_range = ({16'd0, r_addr} < 32'(DEPTH));
  assign w_done     = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_idx      = r_addr[AW-1:0];
  assign o_busy     = (r_state == ST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 16'd0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      o_rd_data <= '0;
      o_ack     <= 1'b0;
      o_oob_err <= 1'b0;
    end else begin
      o_ack     <= 1'b0;
      o_oob_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rd_req || i_wr_req) begin
            r_addr  <= i_addr;
            r_wdata <= i_wr_data;
            r_is_wr <= i_wr_req;   // write wins over a simultaneous read
            r_cnt   <= CNT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            o_ack     <= 1'b1;
            o_oob_err <= !w_in_range;
            if (!r_is_wr)
              o_rd_data <= w_in_range ? r_mem[w_idx] : '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Array is not reset; w_done is gated by the reset state so aborted writes never land.
  always_ff @(posedge clk) begin
    if (w_done && r_is_wr && w_in_range)
      r_mem[w_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_mem_delayed.sv
// Bench for mem_delayed: two instances (LATENCY 4 and 1) checked against a
// time-based reference model every cycle, plus directed literal expectations.
module tb_mem_delayed;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd [2];
  logic        wr [2];
  logic [15:0] ad [2];
  logic [15:0] wd [2];
  logic [15:0] rdo [2];
  logic        ack [2];
  logic        busy [2];
  logic        oob [2];

  int total = 0;
  int passed = 0;
  int acks [2] = '{0, 0};
  int LATS [2] = '{4, 1};

  // reference model state
  int          ecnt = 0;
  bit          m_busy [2] = '{0, 0};
  bit          m_ack [2] = '{0, 0};
  bit          m_oob [2] = '{0, 0};
  logic [15:0] m_rd [2] = '{16'd0, 16'd0};
  int          m_done [2];
  bit          m_w [2];
  logic [15:0] m_a [2];
  logic [15:0] m_d [2];
  logic [15:0] mm [2][256];

  mem_delayed #(.WIDTH(16), .DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .i_rd_req(rd[0]), .i_wr_req(wr[0]), .i_addr(ad[0]),
    .i_wr_data(wd[0]), .o_rd_data(rdo[0]), .o_ack(ack[0]), .o_busy(busy[0]),
    .o_oob_err(oob[0]));

  mem_delayed #(.WIDTH(16), .DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .i_rd_req(rd[1]), .i_wr_req(wr[1]), .i_addr(ad[1]),
    .i_wr_data(wd[1]), .o_rd_data(rdo[1]), .o_ack(ack[1]), .o_busy(busy[1]),
    .o_oob_err(oob[1]));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: an access accepted at edge c completes at edge c+LATENCY.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0; m_ack[k] <= 1'b0; m_oob[k] <= 1'b0; m_rd[k] <= 16'd0;
      end
    end else begin
      ecnt <= ecnt + 1;
      for (int k = 0; k < 2; k++) begin
        m_ack[k] <= 1'b0;
        m_oob[k] <= 1'b0;
        if (m_busy[k]) begin
          if (ecnt == m_done[k]) begin
            m_busy[k] <= 1'b0;
            m_ack[k]  <= 1'b1;
            m_oob[k]  <= (m_a[k] >= 16'd256);
            if (m_w[k]) begin
              if (m_a[k] < 16'd256) mm[k][m_a[k][7:0]] <= m_d[k];
            end else begin
              m_rd[k] <= (m_a[k] < 16'd256) ? mm[k][m_a[k][7:0]] : 16'd0;
            end
          end
        end else if (rd[k] || wr[k]) begin
          m_busy[k] <= 1'b1;
          m_done[k] <= ecnt + LATS[k];
          m_w[k]    <= wr[k];
          m_a[k]    <= ad[k];
          m_d[k]    <= wd[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model ack[%0d]", k),  32'(ack[k]),  32'(m_ack[k]));
      chk($sformatf("model busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("model oob[%0d]", k),  32'(oob[k]),  32'(m_oob[k]));
      chk($sformatf("model rd_data[%0d]", k), 32'(rdo[k]), 32'(m_rd[k]));
    end
  end

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) if (ack[k] === 1'b1) acks[k]++;
  end

  // One access on instance k from idle; returns data/oob at ack and edges-to-ack.
  task automatic access(input int k, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rdd, output logic o,
                        output int lat);
    bit got;
    @(negedge clk);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = ~a; wd[k] = ~d;
    got = 1'b0; lat = 0; rdd = 16'd0; o = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack[k] === 1'b1) begin
        got = 1'b1; rdd = rdo[k]; o = oob[k];
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic [15:0] e;
    logic        o;
    int          l;
    int          n;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = 16'd0; wd[k] = 16'd0;
    end
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset ack", 32'(ack[0]), 0);
    chk("reset rd_data", 32'(rdo[0]), 0);
    chk("reset oob", 32'(oob[0]), 0);
    rst = 1'b0;

    // write then read
    access(0, 0, 1, 16'h0010, 16'hBEEF, r, o, l);
    chk("wr lat", l, 4); chk("wr oob", 32'(o), 0);
    access(0, 1, 0, 16'h0010, 16'h0000, r, o, l);
    chk("rd lat", l, 4); chk("rd data", 32'(r), 32'hBEEF); chk("rd oob", 32'(o), 0);
    repeat (3) @(negedge clk);
    chk("rd hold", 32'(rdo[0]), 32'hBEEF);

    // busy backpressure
    access(0, 0, 1, 16'd3, 16'h0777, r, o, l);
    @(negedge clk); n = acks[0];
    rd[0] = 1'b1; ad[0] = 16'd3;
    @(negedge clk); rd[0] = 1'b0;
    chk("bp busy", 32'(busy[0]), 1);
    wr[0] = 1'b1; wd[0] = 16'h1234;
    @(negedge clk); wr[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("bp one ack", acks[0] - n, 1);
    access(0, 1, 0, 16'd3, 16'h0000, r, o, l);
    chk("bp reread", 32'(r), 32'h0777);

    // simultaneous read and write
    @(negedge clk); n = acks[0];
    access(0, 1, 1, 16'h0020, 16'h00AA, r, o, l);
    chk("rw lat", l, 4); chk("rw rd_data unchanged", 32'(r), 32'h0777);
    repeat (6) @(negedge clk);
    chk("rw one ack", acks[0] - n, 1);
    access(0, 1, 0, 16'h0020, 16'h0000, r, o, l);
    chk("rw reread", 32'(r), 32'h00AA);

    // out of range
    access(0, 0, 1, 16'h0000, 16'h1357, r, o, l);
    access(0, 0, 1, 16'h0100, 16'h5555, r, o, l);
    chk("oob wr flag", 32'(o), 1);
    access(0, 1, 0, 16'h0100, 16'h0000, r, o, l);
    chk("oob rd flag", 32'(o), 1); chk("oob rd data", 32'(r), 0);
    access(0, 1, 0, 16'hFF00, 16'h0000, r, o, l);
    chk("oob hi flag", 32'(o), 1); chk("oob hi data", 32'(r), 0);
    access(0, 1, 0, 16'h0000, 16'h0000, r, o, l);
    chk("alias untouched", 32'(r), 32'h1357); chk("alias oob", 32'(o), 0);

    // LATENCY=1 streaming reads
    for (int i = 0; i < 4; i++) begin
      access(1, 0, 1, 16'(i), 16'h1000 + 16'(i), r, o, l);
      chk("l1 wr lat", l, 1);
    end
    @(negedge clk); rd[1] = 1'b1; ad[1] = 16'd0;
    for (int i = 0; i < 4; i++) begin
      e = 16'h1000 + 16'(i);
      @(posedge clk); #1;
      chk("l1 busy hi", 32'(busy[1]), 1); chk("l1 no ack", 32'(ack[1]), 0);
      @(posedge clk); #1;
      chk("l1 ack", 32'(ack[1]), 1); chk("l1 busy lo", 32'(busy[1]), 0);
      chk("l1 data", 32'(rdo[1]), 32'(e));
      if (i < 3) ad[1] = 16'(i + 1);
      else rd[1] = 1'b0;
    end

    // reset mid-write
    access(0, 0, 1, 16'd5, 16'h0001, r, o, l);
    @(negedge clk); n = acks[0];
    wr[0] = 1'b1; ad[0] = 16'd5; wd[0] = 16'hCAFE;
    @(posedge clk); #1; wr[0] = 1'b0;
    chk("mid busy", 32'(busy[0]), 1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rst busy", 32'(busy[0]), 0); chk("rst ack", 32'(ack[0]), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst no ack", acks[0] - n, 0);
    access(0, 1, 0, 16'd5, 16'h0000, r, o, l);
    chk("rst reread", 32'(r), 32'h0001); chk("rst rd lat", l, 4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
